// File: rtl/addsub_pipe_st.sv
// Pipelined NBITS adder/subtractor: the carry chain is cut into NSTAGES chunks, one per stage,
// with operand skew/result deskew so the whole word leaves the last stage together.
module addsub_pipe_st #(
  parameter int NBITS   = 16,
  parameter int NSTAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = NBITS / NSTAGES;
  localparam int L  = NSTAGES - 1;

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole pipe
  // advances only when the output slot is empty or being drained, so in_ready == en.
  logic en;

  logic [NSTAGES-1:0] vld_q;
  logic [NSTAGES-1:0] cy_q;
  logic [NBITS-1:0]   a_q [NSTAGES];
  logic [NBITS-1:0]   b_q [NSTAGES];
  logic [NBITS-1:0]   r_q [NSTAGES];
  logic               ovf_q;
  logic               zero_q;

  logic [NSTAGES-1:0] src_v;
  logic [NSTAGES-1:0] src_c;
  logic [NSTAGES-1:0] cy_d;
  logic [NBITS-1:0]   src_a [NSTAGES];
  logic [NBITS-1:0]   src_b [NSTAGES];
  logic [NBITS-1:0]   src_r [NSTAGES];
  logic [NBITS-1:0]   r_d   [NSTAGES];
  logic [CW:0]        sum   [NSTAGES];
  logic               ovf_d;
  logic               zero_d;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  always_comb begin
    src_v[0] = in_valid;
    src_c[0] = sub ? 1'b1 : cin;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_r[0] = '0;
    for (int s = 1; s < NSTAGES; s++) begin
      src_v[s] = vld_q[s-1];
      src_c[s] = cy_q[s-1];
      src_a[s] = a_q[s-1];
      src_b[s] = b_q[s-1];
      src_r[s] = r_q[s-1];
    end
    for (int s = 0; s < NSTAGES; s++) begin
      sum[s] = {1'b0, src_a[s][s*CW +: CW]} + {1'b0, src_b[s][s*CW +: CW]}
             + {{CW{1'b0}}, src_c[s]};
      r_d[s] = src_r[s];
      r_d[s][s*CW +: CW] = sum[s][CW-1:0];
      cy_d[s] = sum[s][CW];
    end
    // Carry into the MSB is recovered from the MSB sum bit of the top chunk.
    ovf_d  = (src_a[L][NBITS-1] ^ src_b[L][NBITS-1] ^ sum[L][CW-1]) ^ sum[L][CW];
    zero_d = ~|r_d[L];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < NSTAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        r_q[s] <= '0;
      end
    end else if (en) begin
      vld_q <= src_v;
      // Data registers only load behind a valid op, so bubbles leave flags untouched.
      for (int s = 0; s < NSTAGES; s++) begin
        if (src_v[s]) begin
          cy_q[s] <= cy_d[s];
          a_q[s]  <= src_a[s];
          b_q[s]  <= src_b[s];
          r_q[s]  <= r_d[s];
        end
      end
      if (src_v[L]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = vld_q[L];
  assign r         = r_q[L];
  assign cout      = cy_q[L];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_pipe_st.sv
// Bench for addsub_pipe_st: three instances (4, 1 and 16 stages) driven one at a time,
// checked against an arithmetic model plus hand-computed vectors.
module tb_addsub_pipe_st;

  localparam int NI = 3;
  localparam int NV = 9;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        s;
    logic [15:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   a, b;
  logic          cin, sub, rdy;
  logic [NI-1:0] iv, ir, ov, co, of, zr;
  logic [15:0]   rr [NI];

  int            sel;
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_emit = 0;
  logic [18:0]   exp_q [$];
  logic [18:0]   e;

  vec_t vecs [NV] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0},
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0},
    '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0}
  };

  logic [15:0] t5a [8] = '{16'hA5A5, 16'h0001, 16'hFFFF, 16'h7000, 16'h1234, 16'h8000, 16'h0F0F, 16'hC000};
  logic [15:0] t5b [8] = '{16'h5A5B, 16'h0002, 16'hFFFF, 16'h1000, 16'h1234, 16'h8000, 16'hF0F0, 16'h4000};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int ST = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    addsub_pipe_st #(.NBITS(16), .NSTAGES(ST)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(ov[g]),
      .out_ready(rdy),
      .r        (rr[g]),
      .cout     (co[g]),
      .ovf      (of[g]),
      .zero     (zr[g])
    );
  end

  function automatic int nst(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
  endfunction

  // Returns {zero, ovf, cout, r} from signed/unsigned integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    int          s_sum;
    logic        c_o;
    logic        o_v;
    logic [15:0] res;
    if (ms) begin
      s_sum = int'($signed(ma)) - int'($signed(mb));
      c_o   = (ma >= mb);
    end else begin
      s_sum = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
      c_o   = (int'(ma) + int'(mb) + int'(mc)) > 65535;
    end
    res = 16'(s_sum);
    o_v = (s_sum > 32767) || (s_sum < -32768);
    return {res == 16'h0000, o_v, c_o, res};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exv, $time);
    end
  endtask

  // Scoreboard push: every accepted op on the active instance.
  always @(posedge clk) begin
    if (rst_n && iv[sel] && ir[sel]) exp_q.push_back(model(a, b, cin, sub));
  end

  // Compare process: every cycle an output is valid it must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (ov[i]) begin
          if (i != sel || exp_q.size() == 0) begin
            chk("spurious_out_valid", 32'(ov[i]), 32'd0);
          end else begin
            e = exp_q[0];
            chk("r",    32'(rr[i]), 32'(e[15:0]));
            chk("cout", 32'(co[i]), 32'(e[16]));
            chk("ovf",  32'(of[i]), 32'(e[17]));
            chk("zero", 32'(zr[i]), 32'(e[18]));
            if (!rdy) chk("stall_in_ready", 32'(ir[i]), 32'd0);
            else begin
              void'(exp_q.pop_front());
              n_emit++;
            end
          end
        end
      end
    end
  end

  task automatic single(input int i, input int v);
    vec_t t;
    int   lat;
    t = vecs[v];
    @(posedge clk); #1;
    sel = i; a = t.a; b = t.b; cin = t.c; sub = t.s; rdy = 1'b1; iv[i] = 1'b1;
    #1 chk("idle_in_ready", 32'(ir[i]), 32'd1);
    @(posedge clk); #1;
    iv[i] = 1'b0;
    lat = 1;
    while (!ov[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, nst(i));
    chk("vec_r",    32'(rr[i]), 32'(t.r));
    chk("vec_cout", 32'(co[i]), 32'(t.co));
    chk("vec_ovf",  32'(of[i]), 32'(t.ov));
    chk("vec_zero", 32'(zr[i]), 32'(t.r == 16'h0000));
    @(posedge clk);
  endtask

  initial begin
    int   k;
    int   base;
    logic acc;
    rst_n = 1'b0; iv = '0; rdy = 1'b0; sel = 0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", 32'(ov[i]), 32'd0);
      chk("rst_r",         32'(rr[i]), 32'd0);
      chk("rst_cout",      32'(co[i]), 32'd0);
      chk("rst_ovf",       32'(of[i]), 32'd0);
      chk("rst_zero",      32'(zr[i]), 32'd0);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) chk("post_rst_in_ready", 32'(ir[i]), 32'd1);

    // Directed vectors on every depth
    for (int i = 0; i < NI; i++)
      for (int v = 0; v < NV; v++) single(i, v);

    // Back-to-back ops with a three-cycle output stall
    @(posedge clk); #1;
    sel = 0; k = 0; base = n_emit;
    for (int c = 0; c < 40 && k < 8; c++) begin
      rdy = !(c >= 5 && c <= 7);
      a = t5a[k]; b = t5b[k]; sub = k[0]; cin = k[1]; iv[0] = 1'b1;
      #1 acc = iv[0] && ir[0];
      @(posedge clk); #1;
      if (acc) k++;
    end
    iv[0] = 1'b0; rdy = 1'b1;
    chk("t5_accepted", k, 8);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_emitted", n_emit - base, 8);

    // Reset with ops in flight
    sel = 0; rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = 16'h1000 * 16'(j + 1); b = 16'h0011; sub = 1'b0; cin = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_out_valid", 32'(ov[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_r",         32'(rr[0]), 32'd0);
    chk("midrst_cout",      32'(co[0]), 32'd0);
    chk("midrst_ovf",       32'(of[0]), 32'd0);
    chk("midrst_zero",      32'(zr[0]), 32'd0);
    exp_q.delete();
    #10 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("after_rst_in_ready", 32'(ir[0]), 32'd1);
    chk("after_rst_no_output", 32'(ov), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog timeout");
  end

endmodule
